ex_fsm_stim: RTL

- Drives the single-bit pattern input A of the team's four-phase pattern-detect FSM (IDLE->START->STOP->CLEAR) and checks that FSM's k1/k2 responses. It is the sending end of that interface.
- It emits the A sequence high, low, high, low, with a programmable hold per phase. It samples k1/k2 at fixed points and reports pass/fail.
- It sits beside the detector in the ex_3 lab top and is driven by a key or a test controller.

---
 rtl/ex_fsm_stim.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ex_fsm_stim.sv
// Stimulus and checker for the four-phase pattern detector.
// Drives A high/low/high/low, samples k1/k2, reports pass.
module ex_fsm_stim #(
  parameter int HOLD_W  = 8,
  parameter int CHK_DLY = 2
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [HOLD_W-1:0] hold_len,
  input  logic              k1,
  input  logic              k2,
  output logic              a_out,
  output logic              busy,
  output logic              done,
  output logic              pass
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_H1   = 3'd1,
    S_L1   = 3'd2,
    S_H2   = 3'd3,
    S_L2   = 3'd4,
    S_CHK  = 3'd5
  } state_e;

  localparam logic [HOLD_W-1:0] CHK_LD = HOLD_W'(CHK_DLY - 1);

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [HOLD_W-1:0] lm1_q, lm1_d;
  logic              err_q, err_d;
  logic              a_q, a_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  logic [HOLD_W-1:0] lm1_new;
  logic [HOLD_W-1:0] cnt_dec;
  logic              last;
  logic              err_fin;

  // hold values below 2 are clamped to 2; store L-1 for reloads
  assign lm1_new = (hold_len < HOLD_W'(2)) ? HOLD_W'(1)
                                           : hold_len - HOLD_W'(1);
  assign cnt_dec = cnt_q - HOLD_W'(1);
  assign last    = (cnt_q == '0);
  assign err_fin = err_q | ~k1 | k2;

  // state, counter and output registers
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lm1_q   <= '0;
      err_q   <= 1'b0;
      a_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lm1_q   <= lm1_d;
      err_q   <= err_d;
      a_q     <= a_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // phase sequencing, k1/k2 sampling and result
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lm1_d   = lm1_q;
    err_d   = err_q;
    a_d     = a_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: begin
        a_d    = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          state_d = S_H1;
          a_d     = 1'b1;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = 1'b0;
          cnt_d   = lm1_new;
          lm1_d   = lm1_new;
        end
      end
      S_H1: begin
        if (last) begin
          state_d = S_L1;
          a_d     = 1'b0;
          cnt_d   = lm1_q;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_L1: begin
        if (last) begin
          state_d = S_H2;
          a_d     = 1'b1;
          cnt_d   = lm1_q;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_H2: begin
        if (last) begin
          state_d = S_L2;
          a_d     = 1'b0;
          cnt_d   = lm1_q;
          err_d   = err_q | k1 | ~k2;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_L2: begin
        if (last) begin
          state_d = S_CHK;
          a_d     = 1'b0;
          cnt_d   = CHK_LD;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_CHK: begin
        a_d = 1'b0;
        if (last) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = err_fin;
          pass_d  = ~err_fin;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      default: begin
        state_d = S_IDLE;
        a_d     = 1'b0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  assign a_out = a_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign pass  = pass_q;

endmodule
